// File: rtl/mul16_seq_pkg.sv
// mul16_seq_pkg
//   Shared types and constants for the sequential 16x16 multiplier.
//   - state_t     : sequencer states (IDLE, MUL, DONE)
//   - STEP_*      : step encodings; bit 0 selects the high byte of a_q,
//                   bit 1 selects the high byte of b_q
//   - step_shift(): left shift applied to a step's 16-bit partial product
package mul16_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] STEP_LL = 2'd0;  // a_q[7:0]  * b_q[7:0]
  localparam logic [1:0] STEP_HL = 2'd1;  // a_q[15:8] * b_q[7:0]
  localparam logic [1:0] STEP_LH = 2'd2;  // a_q[7:0]  * b_q[15:8]
  localparam logic [1:0] STEP_HH = 2'd3;  // a_q[15:8] * b_q[15:8]

  // Byte weight of a partial product: 0, 8, 8 or 16 bit positions.
  function automatic logic [4:0] step_shift(input logic [1:0] step);
    logic [4:0] sh;
    case (step)
      STEP_LL: sh = 5'd0;
      STEP_HL: sh = 5'd8;
      STEP_LH: sh = 5'd8;
      STEP_HH: sh = 5'd16;
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul16_seq_mul8_unit.sv
// mul8_unit
//   Unsigned 8x8 -> 16 combinational multiplier. It is the only multiply
//   array in the sequencer and is time-shared across the four steps.
//   Ports:
//     a      in  8   multiplicand byte
//     b      in  8   multiplier byte
//     result out 16  a * b
module mul8_unit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result
);

  assign result = 16'(a) * 16'(b);

endmodule

// File: rtl/mul16_seq.sv
// mul16_seq
//   Unsigned 16x16 -> 32 multiplier that runs one shared 8x8 array over four
//   cycles, accumulating byte-weighted partial products.
//
//   Handshakes: a transfer on either interface happens on a rising clock edge
//   where both valid and ready are high. req_ready is high only in IDLE and
//   resp_valid only in DONE; product and resp_valid are held stable until the
//   consumer raises resp_ready. Neither ready nor valid depends
//   combinationally on the other side's signal.
//
//   Parameters:
//     SKIP_ZERO  1: a request with a zero operand skips the MUL steps.
//   Ports:
//     clk        in   1   clock, rising edge
//     rst        in   1   synchronous active-high reset
//     req_valid  in   1   requester presents a/b
//     req_ready  out  1   ready to accept (IDLE)
//     a          in  16   multiplicand, sampled on accept
//     b          in  16   multiplier, sampled on accept
//     resp_valid out  1   product valid (DONE)
//     resp_ready in   1   consumer takes the product
//     product    out 32   accumulator register
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter int SKIP_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] product
);

  state_t      state;
  logic [1:0]  step;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc;

  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] partial;
  logic [31:0] partial_shifted;
  logic        zero_operand;

  // Operand byte selection follows the STEP_* encoding directly.
  assign mul_a = step[0] ? a_q[15:8] : a_q[7:0];
  assign mul_b = step[1] ? b_q[15:8] : b_q[7:0];

  mul8_unit u_mul8 (
    .a      (mul_a),
    .b      (mul_b),
    .result (partial)
  );

  assign partial_shifted = {16'd0, partial} << step_shift(step);
  assign zero_operand    = (SKIP_ZERO != 0) && ((a == 16'd0) || (b == 16'd0));

  // Outputs are pure decodes of registered state.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign product    = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= STEP_LL;
      acc   <= 32'd0;
      a_q   <= 16'd0;
      b_q   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q  <= a;
            b_q  <= b;
            acc  <= 32'd0;
            step <= STEP_LL;
            // A zero operand already has the right product (acc cleared).
            state <= zero_operand ? DONE : MUL;
          end
        end
        MUL: begin
          // Sum of all partials is < 2^32, so the wrap never happens.
          acc <= acc + partial_shifted;
          if (step == STEP_HH) begin
            step  <= STEP_LL;
            state <= DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          step  <= STEP_LL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
module tb_mul16_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [15:0] a, b;
  logic [31:0] product;

  logic        req_valid_nz, req_ready_nz, resp_valid_nz, resp_ready_nz;
  logic [31:0] product_nz;

  mul16_seq #(.SKIP_ZERO(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .product    (product)
  );

  mul16_seq #(.SKIP_ZERO(0)) dut_nz (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid_nz),
    .req_ready  (req_ready_nz),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid_nz),
    .resp_ready (resp_ready_nz),
    .product    (product_nz)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops on the first cycle of each response, then checks that the
  // product stays put while the response waits.
  bit          in_resp = 1'b0;
  logic [31:0] cur_exp;
  int          cur_due;
  always @(negedge clk) begin
    if (rst) begin
      in_resp = 1'b0;
    end else if (resp_valid) begin
      if (!in_resp) begin
        in_resp = 1'b1;
        if (exp_q.size() == 0) begin
          fail("unexpected_resp");
          cur_exp = product;
        end else begin
          cur_exp = exp_q.pop_front();
          cur_due = due_q.pop_front();
          check("product", product, cur_exp);
          check("resp_cycle", cyc, cur_due);
        end
      end else begin
        check("held_product", product, cur_exp);
      end
      check("ready_in_done", {31'd0, req_ready}, 32'd0);
    end else begin
      in_resp = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Present a request and hold req_valid until accepted. Returns at the
  // negedge of the accept cycle with req_valid still high.
  task automatic send(input logic [15:0] av, input logic [15:0] bv,
                      input logic [31:0] exp, input int lat, input bit push,
                      output int acc_cyc);
    @(negedge clk);
    req_valid = 1'b1;
    a = av;
    b = bv;
    for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      fail("accept_timeout");
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
      if (push) begin
        exp_q.push_back(exp);
        due_q.push_back(cyc + lat);
      end
    end
  endtask

  task automatic stop_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && !(req_ready && !resp_valid); i++) @(negedge clk);
    if (!(req_ready && !resp_valid)) fail("idle_timeout");
  endtask

  // ---------------- stimulus ----------------
  int acc_c, prev_c, nz_c;
  logic [15:0] ra, rb;

  initial begin
    rst = 1'b1; req_valid = 1'b0; a = '0; b = '0; resp_ready = 1'b1;
    req_valid_nz = 1'b0; resp_ready_nz = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_nz_req_ready", {31'd0, req_ready_nz}, 32'd1);

    // Basic product; req_valid stays high to show it is taken only once.
    send(16'h1234, 16'h5678, 32'h0626_0060, 5, 1'b1, acc_c);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("busy_req_ready", {31'd0, req_ready}, 32'd0);
      if (i == 5) req_valid = 1'b0;
    end
    wait_idle();

    // Maximum operands.
    send(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 5, 1'b1, acc_c);
    stop_req();
    wait_idle();

    // Zero skip on the SKIP_ZERO=1 instance.
    send(16'h0000, 16'hABCD, 32'd0, 1, 1'b1, acc_c);
    stop_req();
    wait_idle();

    // Same stimulus on the SKIP_ZERO=0 instance: full four steps.
    @(negedge clk);
    a = 16'h0000;
    b = 16'hABCD;
    req_valid_nz = 1'b1;
    check("nz_req_ready", {31'd0, req_ready_nz}, 32'd1);
    nz_c = cyc;
    @(negedge clk);
    req_valid_nz = 1'b0;
    for (int i = 0; i < 40 && !resp_valid_nz; i++) @(negedge clk);
    if (!resp_valid_nz) fail("nz_resp_timeout");
    else begin
      check("nz_resp_cycle", cyc - nz_c, 32'd5);
      check("nz_product", product_nz, 32'd0);
    end

    // Backpressure.
    resp_ready = 1'b0;
    send(16'h00FF, 16'h0100, 32'h0000_FF00, 5, 1'b1, acc_c);
    stop_req();
    for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
    if (!resp_valid) fail("bp_resp_timeout");
    for (int i = 0; i < 3; i++) begin
      check("bp_product", product, 32'h0000_FF00);
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    check("bp_release_valid", {31'd0, resp_valid}, 32'd0);

    // Reset mid-operation: no response may appear for the aborted request.
    send(16'h1234, 16'h5678, 32'd0, 5, 1'b0, acc_c);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_product", product, 32'd0);
    rst = 1'b0;
    send(16'd3, 16'd5, 32'd15, 5, 1'b1, acc_c);
    stop_req();
    wait_idle();

    // Back-to-back with req_valid held high.
    prev_c = -1;
    for (int k = 0; k < 8; k++) begin
      ra = 16'($urandom_range(1, 16'hFFFF));
      rb = 16'($urandom_range(1, 16'hFFFF));
      send(ra, rb, 32'(ra) * 32'(rb), 5, 1'b1, acc_c);
      if (k > 0) check("accept_spacing", acc_c - prev_c, 32'd6);
      prev_c = acc_c;
    end
    stop_req();
    wait_idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
